// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external 32-bit combinational ALU between two requesters.
// Each requester presents an operation on a valid/ready request channel and
// gets its result plus zero flag back on a valid/ready response channel.
//
// A round-robin pointer (prio_reg) picks the winner when both requesters are
// valid in the same IDLE cycle; a lone requester always wins. A three-state
// sequencer (IDLE -> EXEC -> RESP) latches the operands, drives the ALU for
// exactly one cycle, captures the result and holds it until the owner takes it.
// Operations never overlap, so one operation occupies at least three cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake (ready only in IDLE, only for
//                              the granted requester)
//   reqN_op, reqN_a, reqN_b    operation and operands (op forwarded unchecked)
//   rspN_valid / rspN_ready    response handshake (only the owner is valid)
//   rspN_z, rspN_zero          result and zero flag (0 unless rspN_valid)
//   alu_a, alu_b, alu_op       to the shared ALU, straight from the latched
//                              operand registers; meaningful during EXEC
//   alu_z, alu_zero            from the shared ALU, sampled at the end of EXEC
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_z,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_z,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic               owner_reg;   // requester that owns the in-flight op
    logic               prio_reg;    // requester favoured on a tie
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   z_reg;
    logic               zero_reg;

    // -------------------------------------------------------------------------
    // Arbitration. A lone requester wins; on a tie the pointer decides.
    // grant0/grant1 are mutually exclusive by construction.
    // -------------------------------------------------------------------------
    logic grant0;
    logic grant1;
    logic is_idle;
    logic is_resp;

    assign grant1  = req1_valid & (~req0_valid | prio_reg);
    assign grant0  = req0_valid & (~req1_valid | ~prio_reg);
    assign is_idle = (state_reg == IDLE);
    assign is_resp = (state_reg == RESP);

    assign req0_ready = is_idle & grant0;
    assign req1_ready = is_idle & grant1;

    // Owner's response-ready, selected once so the FSM stays compact.
    logic owner_rsp_ready;
    assign owner_rsp_ready = owner_reg ? rsp1_ready : rsp0_ready;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            prio_reg  <= 1'b0;
            op_reg    <= 3'b000;
            a_reg     <= '0;
            b_reg     <= '0;
            z_reg     <= '0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0 | grant1) begin
                        op_reg    <= grant1 ? req1_op : req0_op;
                        a_reg     <= grant1 ? req1_a  : req0_a;
                        b_reg     <= grant1 ? req1_b  : req0_b;
                        owner_reg <= grant1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    z_reg     <= alu_z;
                    zero_reg  <= alu_zero;
                    // Hand the tie-break to whoever did not just get served.
                    prio_reg  <= ~owner_reg;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // ALU drive: operand registers go out unchanged in every state.
    // -------------------------------------------------------------------------
    assign alu_a  = a_reg;
    assign alu_b  = b_reg;
    assign alu_op = op_reg;

    // -------------------------------------------------------------------------
    // Response channels. Each channel is valid only for the owner in RESP and
    // shows zeros whenever it is not valid.
    // -------------------------------------------------------------------------
    logic [1:0]       rsp_valid_vec;
    logic [1:0]       rsp_zero_vec;
    logic [WIDTH-1:0] rsp_z_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid_vec[gi] = is_resp & (owner_reg == gi[0]);
        assign rsp_z_arr[gi]     = rsp_valid_vec[gi] ? z_reg : '0;
        assign rsp_zero_vec[gi]  = rsp_valid_vec[gi] & zero_reg;
    end

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_z     = rsp_z_arr[0];
    assign rsp1_z     = rsp_z_arr[1];
    assign rsp0_zero  = rsp_zero_vec[0];
    assign rsp1_zero  = rsp_zero_vec[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A behavioural ALU stands in for the shared
// external ALU. Inputs change on the falling edge; outputs are sampled 1ns
// after the falling edge, well away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp0_z, rsp1_z;
    logic         rsp0_zero, rsp1_zero;
    logic [W-1:0] alu_a, alu_b, alu_z;
    logic [2:0]   alu_op;
    logic         alu_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
        .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
        .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_zero(alu_zero)
    );

    // Stand-in shared ALU. Undefined op codes return a^b so forwarding of
    // those codes is visible in the result.
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_z = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_z == '0);
    end

    typedef struct {
        int         who;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic       zero;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int who, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic set_rsp_ready(input int who, input logic v);
        if (who == 0) rsp0_ready = v;
        else          rsp1_ready = v;
    endtask

    function automatic logic rdy(input int who);
        return (who == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rvalid(input int who);
        return (who == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [W-1:0] rz(input int who);
        return (who == 0) ? rsp0_z : rsp1_z;
    endfunction

    function automatic logic rzero(input int who);
        return (who == 0) ? rsp0_zero : rsp1_zero;
    endfunction

    // One complete lone-requester operation with exact cycle placement:
    // ready in IDLE, ALU driven in the cycle after the handshake, response
    // valid in the cycle after that, idle again after the response handshake.
    task automatic do_op(input vec_t v, input string name);
        int n;
        int o;
        o = 1 - v.who;
        @(negedge clk);
        set_req(v.who, 1'b1, v.op, v.a, v.b);
        #1;
        n = 0;
        while (!rdy(v.who) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk({name, ".ready"}, {31'b0, rdy(v.who)}, 1);
        chk({name, ".other_ready"}, {31'b0, rdy(o)}, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(v.who, 1'b0, 3'b000, '0, '0);
        #1;
        chk({name, ".alu_a"}, alu_a, v.a);
        chk({name, ".alu_b"}, alu_b, v.b);
        chk({name, ".alu_op"}, {29'b0, alu_op}, {29'b0, v.op});
        chk({name, ".exec_valid"}, {31'b0, rvalid(v.who)}, 0);
        @(negedge clk); #1;
        chk({name, ".rsp_valid"}, {31'b0, rvalid(v.who)}, 1);
        chk({name, ".rsp_z"}, rz(v.who), v.z);
        chk({name, ".rsp_zero"}, {31'b0, rzero(v.who)}, {31'b0, v.zero});
        chk({name, ".other_valid"}, {31'b0, rvalid(o)}, 0);
        chk({name, ".other_z"}, rz(o), 0);
        set_rsp_ready(v.who, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rsp_ready(v.who, 1'b0);
        #1;
        chk({name, ".after_valid"}, {31'b0, rvalid(v.who)}, 0);
        chk({name, ".after_z"}, rz(v.who), 0);
        $display("op %s who=%0d op=%b a=%h b=%h z=%h", name, v.who, v.op, v.a, v.b, v.z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gwho [4];
        int gcyc [4];
        int ng;
        int nresp;
        int r_edge;
        vec_t pre;

        //          who op      a             b             z             zero
        vecs[0] = '{0, 3'b010, 32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1] = '{1, 3'b110, 32'd9,        32'd9,        32'd0,        1'b1};
        vecs[2] = '{1, 3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[3] = '{0, 3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vecs[4] = '{1, 3'b001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        vecs[5] = '{0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[6] = '{0, 3'b111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[7] = '{1, 3'b110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
        vecs[8] = '{1, 3'b011, 32'h000000A5, 32'h0000000F, 32'h000000AA, 1'b0};

        set_req(0, 1'b0, 3'b000, '0, '0);
        set_req(1, 1'b0, 3'b000, '0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("rst.req0_ready", {31'b0, req0_ready}, 0);
        chk("rst.req1_ready", {31'b0, req1_ready}, 0);
        chk("rst.rsp0_valid", {31'b0, rsp0_valid}, 0);
        chk("rst.rsp1_valid", {31'b0, rsp1_valid}, 0);
        chk("rst.rsp0_z", rsp0_z, 0);
        chk("rst.rsp1_z", rsp1_z, 0);
        chk("rst.rsp_zero", {30'b0, rsp1_zero, rsp0_zero}, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.alu_b", alu_b, 0);
        chk("rst.alu_op", {29'b0, alu_op}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven single operations ----------------
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- fairness from reset ----------------
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_req(0, 1'b1, 3'b000, 32'h0000F0F0, 32'h0000FF00);
        set_req(1, 1'b1, 3'b001, 32'h0000F0F0, 32'h0000FF00);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        ng = 0;
        nresp = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            chk("fair.onehot", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_ready || req1_ready) begin
                gwho[ng] = req1_ready ? 1 : 0;
                gcyc[ng] = cyc;
                $display("grant %0d to req%0d at cycle %0d", ng, gwho[ng], cyc);
                ng++;
            end
            if (rsp0_valid) begin chk("fair.rsp0_z", rsp0_z, 32'h0000F000); nresp++; end
            if (rsp1_valid) begin chk("fair.rsp1_z", rsp1_z, 32'h0000FFF0); nresp++; end
            @(negedge clk);
        end
        chk("fair.grants", ng, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fair.order%0d", k), gwho[k], k % 2);
            if (k > 0) chk($sformatf("fair.spacing%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        chk("fair.nresp", nresp, 3);
        set_req(0, 1'b0, 3'b000, '0, '0);
        set_req(1, 1'b0, 3'b000, '0, '0);
        repeat (4) @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // ---------------- response stall with competing requester ----------------
        set_req(0, 1'b1, 3'b010, 32'h100, 32'h23);
        set_req(1, 1'b1, 3'b110, 32'h50, 32'h8);
        #1;
        chk("stall.req0_ready", {31'b0, req0_ready}, 1);
        chk("stall.req1_ready_idle", {31'b0, req1_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'b000, '0, '0);
        #1;
        chk("stall.req1_ready_exec", {31'b0, req1_ready}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("stall%0d.valid", i), {31'b0, rsp0_valid}, 1);
            chk($sformatf("stall%0d.z", i), rsp0_z, 32'h123);
            chk($sformatf("stall%0d.req1_ready", i), {31'b0, req1_ready}, 0);
            chk($sformatf("stall%0d.rsp1_valid", i), {31'b0, rsp1_valid}, 0);
        end
        rsp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0;
        r_edge = cyc;
        #1;
        chk("b2b.rsp0_gone", {31'b0, rsp0_valid}, 0);
        chk("b2b.req1_ready", {31'b0, req1_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 3'b000, '0, '0);
        #1;
        chk("b2b.exec_valid", {31'b0, rsp1_valid}, 0);
        @(negedge clk); #1;
        chk("b2b.rsp1_valid", {31'b0, rsp1_valid}, 1);
        chk("b2b.rsp1_z", rsp1_z, 32'h48);
        chk("b2b.latency", cyc - r_edge, 2);
        $display("b2b response consumed edge %0d, next response valid at edge %0d", r_edge, cyc);
        rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp1_ready = 1'b0;

        // ---------------- reset during EXEC ----------------
        pre = '{0, 3'b010, 32'd2, 32'd2, 32'd4, 1'b0};
        do_op(pre, "pre_abort");        // pointer now favours req1
        @(negedge clk);
        set_req(0, 1'b1, 3'b010, 32'h11, 32'h22);
        #1;
        chk("abort.req0_ready", {31'b0, req0_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'b000, '0, '0);
        #1;
        chk("abort.exec_alu_a", alu_a, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("abort.alu_a", alu_a, 0);
        chk("abort.alu_b", alu_b, 0);
        chk("abort.alu_op", {29'b0, alu_op}, 0);
        chk("abort.rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
        chk("abort.rsp0_z", rsp0_z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("abort.quiet%0d", i), {30'b0, rsp1_valid, rsp0_valid}, 0);
            @(negedge clk);
        end
        set_req(0, 1'b1, 3'b000, 32'h3C, 32'h0F);
        set_req(1, 1'b1, 3'b010, 32'd1, 32'd1);
        #1;
        chk("abort.prio_req0", {31'b0, req0_ready}, 1);
        chk("abort.prio_req1", {31'b0, req1_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'b000, '0, '0);
        set_req(1, 1'b0, 3'b000, '0, '0);
        @(negedge clk); #1;
        chk("abort.after_valid", {31'b0, rsp0_valid}, 1);
        chk("abort.after_z", rsp0_z, 32'h0C);
        chk("abort.after_rsp1", {31'b0, rsp1_valid}, 0);
        rsp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
